loa_shared_adder_arbiter: RTL and testbench
===========================================

Name: loa_shared_adder_arbiter

Overview:
- Shares one Lower-part OR adder datapath among NUM_REQ requesters.
- Arbitration is round-robin; each requester uses a valid/ready handshake.
- Each accepted operation is registered with the ID of its requester.
- Sits between accelerator PEs that need occasional additions and the single approximate adder instance. A runtime approx/exact select is included for accuracy experiments.

Parameters:
- BITWIDTH, 8, operand width; result width is BITWIDTH+1.
- BORDER, 2, number of low bits computed by OR in approx mode; legal range 1..BITWIDTH-1.
- NUM_REQ, 4, number of requesters; legal range 2..16.
- ID_W, $clog2(NUM_REQ), width of the requester ID.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_a  in  NUM_REQ*BITWIDTH  packed operand A; requester i uses slice [i*BITWIDTH +: BITWIDTH]
- req_b  in  NUM_REQ*BITWIDTH  packed operand B, same packing as req_a
- req_ready  out  NUM_REQ  one-hot-or-zero accept strobe
- cfg_approx  in  1  1 = LOA mode, 0 = exact add; sampled at acceptance
- resp_valid  out  1  result valid
- resp_ready  in  1  downstream accepts result
- resp_sum  out  BITWIDTH+1  result
- resp_id  out  ID_W  index of the requester that issued the result
- op_count  out  16  accepted-operation counter, saturating

Behaviour:
- Reset (async, active-high): resp_valid=0, resp_sum=0, resp_id=0, rr_ptr=0, op_count=0. While rst is high, req_ready=0.
- Slot free condition: slot_free = !resp_valid || resp_ready.
- Arbitration (combinational):
  - Scan requesters in order starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first i with req_valid[i]=1 is the winner.
  - req_ready[winner] = slot_free. All other req_ready bits are 0.
  - If no requester is valid, req_ready=0.
- Acceptance is req_valid[i] && req_ready[i]. On an acceptance clock edge:
  - resp_valid<=1.
  - resp_sum<=f(a_i,b_i,cfg_approx).
  - resp_id<=i.
  - rr_ptr<=(i+1) mod NUM_REQ.
  - op_count<=op_count+1, saturating at 0xFFFF.
- Latency: exactly 1 cycle from acceptance to resp_valid.
- Throughput: 1 op/cycle when resp_ready is held high.
- Simultaneous drain and accept: in the same cycle the old result is consumed and the new result is loaded. resp_valid stays 1 with no bubble.
- Drain only (resp_valid && resp_ready, no acceptance): resp_valid<=0. resp_sum and resp_id hold their last values.
- Backpressure (resp_valid && !resp_ready):
  - All req_ready=0.
  - resp_sum, resp_id and resp_valid are held stable.
  - rr_ptr is unchanged.
- rr_ptr changes only on acceptance. Idle cycles do not rotate priority.
- Arithmetic when cfg_approx=1 (L = BORDER):
  - sum[L-1:0] = a[L-1:0] | b[L-1:0].
  - sum[BITWIDTH:L] = a[BITWIDTH-1:L] + b[BITWIDTH-1:L] + (a[L-1] & b[L-1]).
- Arithmetic when cfg_approx=0: sum = a + b, zero-extended to BITWIDTH+1.
- Requester-side rule: requesters must hold req_valid, req_a and req_b stable until accepted. The block does not store any request that has not been accepted.
- Reset mid-operation: any pending result is discarded and resp_valid drops immediately (async). After reset release, arbitration restarts at requester 0.
- Fairness: every continuously-valid requester is accepted within NUM_REQ acceptances.

Test Plan:
- Reset/idle: assert rst mid-stream with resp_valid=1 -> resp_valid, resp_sum, resp_id and op_count all read 0 before the next clk edge. After release with no req_valid, req_ready=0 for 10 cycles.
- Approx vs exact: requester 2 sends a=0x0F, b=0x03. With cfg_approx=1 -> resp_sum=0x013, resp_id=2, 1 cycle later. With cfg_approx=0 -> resp_sum=0x012.
- Carry-boundary case: a=0xFF, b=0x01. Approx -> 0x0FF; exact -> 0x100. Also a=0x02, b=0x02, approx -> 0x006 (low-part carry-in used).
- Round-robin: all 4 req_valid held high with resp_ready=1 for 8 cycles -> resp_id sequence 0,1,2,3,0,1,2,3 with no bubbles; op_count=8.
- Backpressure: resp_ready=0 for 5 cycles while requesters 1 and 3 are valid -> req_ready=0 throughout and resp_* held stable. On release -> old result drains and the next result loads in the same cycle.
- Saturation: preload via 65535 acceptances (or force) -> after 3 more acceptances op_count stays 0xFFFF.

Source files
------------

// File: rtl/loa_shared_adder_arbiter.sv
// Round-robin arbiter sharing one Lower-part OR adder (LOA) among NUM_REQ requesters.
// Results are held in a single output slot with valid/ready and tagged with the requester ID.
module loa_shared_adder_arbiter #(
    parameter int BITWIDTH = 8,
    parameter int BORDER   = 2,
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*BITWIDTH-1:0]  req_a,
    input  logic [NUM_REQ*BITWIDTH-1:0]  req_b,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         cfg_approx,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [BITWIDTH:0]            resp_sum,
    output logic [ID_W-1:0]              resp_id,
    output logic [15:0]                  op_count
);

    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     winner;
    logic                found;
    logic                slot_free;
    logic                accept;
    logic [ID_W:0]       idx;
    logic [BITWIDTH-1:0] a_sel;
    logic [BITWIDTH-1:0] b_sel;

    // Upper part gets the carry generated by the top OR'ed bit pair.
    function automatic logic [BITWIDTH:0] loa_add(input logic [BITWIDTH-1:0] a,
                                                  input logic [BITWIDTH-1:0] b,
                                                  input logic approx);
        logic [BITWIDTH-BORDER:0] hi;
        logic                     carry;
        if (!approx) begin
            return {1'b0, a} + {1'b0, b};
        end
        carry = a[BORDER-1] & b[BORDER-1];
        hi = {1'b0, a[BITWIDTH-1:BORDER]} + {1'b0, b[BITWIDTH-1:BORDER]}
             + {{(BITWIDTH-BORDER){1'b0}}, carry};
        return {hi, a[BORDER-1:0] | b[BORDER-1:0]};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    assign slot_free = !resp_valid || resp_ready;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NUM_REQ)) begin
                idx = idx - (ID_W+1)'(NUM_REQ);
            end
            if (!found && req_valid[idx[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[ID_W-1:0];
            end
        end
    end

    assign accept = found && slot_free && !rst;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign a_sel = req_a[int'(winner)*BITWIDTH +: BITWIDTH];
    assign b_sel = req_b[int'(winner)*BITWIDTH +: BITWIDTH];

    // Output slot: accept loads (even while draining), drain alone clears valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_sum   <= '0;
            resp_id    <= '0;
            rr_ptr     <= '0;
            op_count   <= '0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_sum   <= loa_add(a_sel, b_sel, cfg_approx);
            resp_id    <= winner;
            rr_ptr     <= (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + ID_W'(1);
            op_count   <= sat_inc(op_count);
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_loa_shared_adder_arbiter.sv
// Directed self-checking bench for loa_shared_adder_arbiter (BITWIDTH=8, BORDER=2, NUM_REQ=4).
module tb_loa_shared_adder_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        cfg_approx;
    logic        resp_valid;
    logic        resp_ready;
    logic [8:0]  resp_sum;
    logic [1:0]  resp_id;
    logic [15:0] op_count;

    int n_tests = 0;
    int n_fail  = 0;

    loa_shared_adder_arbiter #(
        .BITWIDTH(8), .BORDER(2), .NUM_REQ(4), .ID_W(2)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .cfg_approx(cfg_approx), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_sum(resp_sum), .resp_id(resp_id), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One accepted op from requester idx; called one step after a rising edge.
    task automatic issue(input int idx, input logic [7:0] a, input logic [7:0] b,
                         input logic approx, input logic [8:0] exp_sum);
        req_valid          = '0;
        req_valid[idx]     = 1'b1;
        req_a[idx*8 +: 8]  = a;
        req_b[idx*8 +: 8]  = b;
        cfg_approx         = approx;
        resp_ready         = 1'b1;
        #1;
        check("issue_ready", 32'(req_ready), 32'(4'b0001 << idx));
        @(posedge clk); #1;
        req_valid = '0;
        check("issue_valid", 32'(resp_valid), 32'h1);
        check("issue_sum", 32'(resp_sum), 32'(exp_sum));
        check("issue_id", 32'(resp_id), 32'(idx));
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 4'hF;
        req_a      = 32'h0;
        req_b      = 32'h0;
        cfg_approx = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_valid", 32'(resp_valid), 32'h0);
        check("rst_count", 32'(op_count), 32'h0);
        req_valid = '0;
        rst = 1'b0;
        @(posedge clk); #1;

        // approx vs exact and carry-boundary operands
        issue(2, 8'h0F, 8'h03, 1'b1, 9'h013);
        issue(2, 8'h0F, 8'h03, 1'b0, 9'h012);
        issue(0, 8'hFF, 8'h01, 1'b1, 9'h0FF);
        issue(0, 8'hFF, 8'h01, 1'b0, 9'h100);
        issue(0, 8'h02, 8'h02, 1'b1, 9'h006);
        check("count5", 32'(op_count), 32'd5);

        // asynchronous reset while a result is pending
        resp_ready = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(resp_valid), 32'h0);
        check("mid_rst_sum", 32'(resp_sum), 32'h0);
        check("mid_rst_id", 32'(resp_id), 32'h0);
        check("mid_rst_count", 32'(op_count), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("idle_ready", 32'(req_ready), 32'h0);
            @(posedge clk); #1;
        end

        // round robin with all requesters valid, no bubbles
        req_a      = {8'h40, 8'h30, 8'h20, 8'h10};
        req_b      = {8'h04, 8'h03, 8'h02, 8'h01};
        cfg_approx = 1'b0;
        req_valid  = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check("rr_valid", 32'(resp_valid), 32'h1);
            check("rr_id", 32'(resp_id), 32'(k % 4));
            check("rr_sum", 32'(resp_sum), 32'((k % 4 + 1) * 8'h11));
        end
        req_valid = '0;
        check("rr_count", 32'(op_count), 32'd8);

        // backpressure with requesters 1 and 3 waiting
        resp_ready = 1'b0;
        req_valid  = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_ready", 32'(req_ready), 32'h0);
            @(posedge clk); #1;
            check("bp_valid", 32'(resp_valid), 32'h1);
            check("bp_id", 32'(resp_id), 32'd3);
            check("bp_sum", 32'(resp_sum), 32'h44);
        end
        resp_ready = 1'b1;
        #1;
        check("bp_rel_ready", 32'(req_ready), 32'b0010);
        @(posedge clk); #1;
        check("bp_rel_valid", 32'(resp_valid), 32'h1);
        check("bp_rel_id", 32'(resp_id), 32'd1);
        check("bp_rel_sum", 32'(resp_sum), 32'h22);
        req_valid = 4'b1000;
        @(posedge clk); #1;
        check("bp_next_id", 32'(resp_id), 32'd3);
        check("bp_next_sum", 32'(resp_sum), 32'h44);
        req_valid = '0;
        @(posedge clk); #1;
        check("drain_valid", 32'(resp_valid), 32'h0);
        check("drain_sum", 32'(resp_sum), 32'h44);
        check("count10", 32'(op_count), 32'd10);

        // op_count saturation
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 4'hF;
        repeat (65532) @(posedge clk);
        #1;
        check("sat_pre", 32'(op_count), 32'hFFFC);
        repeat (3) @(posedge clk);
        #1;
        check("sat_hit", 32'(op_count), 32'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        check("sat_hold", 32'(op_count), 32'hFFFF);
        req_valid = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
